// File: rtl/regfile_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq_pkg
// Description : Shared op/state encodings and sequencing rule for regfile_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_seq_pkg;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_MOV   = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // In IDLE the op is the incoming request; elsewhere it is the captured op.
    function automatic state_t seq_next(input state_t s, input logic [1:0] op,
                                        input logic accept);
        state_t n;
        n = s;
        case (s)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOADI: n = S_WR_A;
                        OP_MOV:   n = S_RD_B;
                        default:  n = S_RD_A;
                    endcase
                end
            end
            S_RD_A:  n = (op == OP_READ) ? S_DONE : S_RD_B;
            S_RD_B:  n = S_WR_A;
            S_WR_A:  n = (op == OP_SWAP) ? S_WR_B : S_DONE;
            S_WR_B:  n = S_DONE;
            S_DONE:  n = S_IDLE;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vDFFE.sv
`default_nettype none
// ============================================================================
// Module      : vDFFE
// Description : N-bit register with load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vDFFE #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         en,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    always_ff @(posedge clk) begin
        if (en) begin
            out <= in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_seq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq
// Description : Multi-cycle LOADI/MOV/SWAP/READ sequencer driving a register file.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_ra,
    input  logic [AW-1:0] req_rb,
    input  logic [DW-1:0] req_imm,
    input  logic [DW-1:0] rf_data_out,
    output logic [AW-1:0] rf_readnum,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [DW-1:0] rf_data_in,
    output logic          done,
    output logic [DW-1:0] rsp_data
);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;
    logic [1:0]    w_op_sel;
    logic [1:0]    r_op;
    logic [AW-1:0] r_ra;
    logic [AW-1:0] r_rb;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_tmp_a;
    logic [DW-1:0] r_tmp_b;
    logic          w_rsp_load;

    assign req_ready = (r_state == S_IDLE) & ~reset;
    assign w_accept  = req_valid & req_ready;
    assign w_op_sel  = (r_state == S_IDLE) ? req_op : r_op;

    // Load-enable registers are cleared by forcing a zero load during reset.
    vDFFE #(.N(2)) u_op (
        .clk (clk),
        .en  (w_accept | reset),
        .in  (reset ? 2'b00 : req_op),
        .out (r_op)
    );

    vDFFE #(.N(AW)) u_ra (
        .clk (clk),
        .en  (w_accept | reset),
        .in  (reset ? {AW{1'b0}} : req_ra),
        .out (r_ra)
    );

    vDFFE #(.N(AW)) u_rb (
        .clk (clk),
        .en  (w_accept | reset),
        .in  (reset ? {AW{1'b0}} : req_rb),
        .out (r_rb)
    );

    vDFFE #(.N(DW)) u_imm (
        .clk (clk),
        .en  (w_accept | reset),
        .in  (reset ? {DW{1'b0}} : req_imm),
        .out (r_imm)
    );

    vDFFE #(.N(DW)) u_tmp_a (
        .clk (clk),
        .en  ((r_state == S_RD_A) | reset),
        .in  (reset ? {DW{1'b0}} : rf_data_out),
        .out (r_tmp_a)
    );

    vDFFE #(.N(DW)) u_tmp_b (
        .clk (clk),
        .en  ((r_state == S_RD_B) | reset),
        .in  (reset ? {DW{1'b0}} : rf_data_out),
        .out (r_tmp_b)
    );

    // tmp_a and rsp_data load the same read value on the RD_A->DONE edge.
    assign w_rsp_load = (r_state == S_RD_A) & (r_op == OP_READ);

    vDFFE #(.N(DW)) u_rsp (
        .clk (clk),
        .en  (w_rsp_load | reset),
        .in  (reset ? {DW{1'b0}} : rf_data_out),
        .out (rsp_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = seq_next(r_state, w_op_sel, w_accept);
        rf_readnum   = '0;
        rf_writenum  = '0;
        rf_write     = 1'b0;
        rf_data_in   = '0;
        done         = 1'b0;
        case (r_state)
            S_RD_A: rf_readnum = r_ra;
            S_RD_B: rf_readnum = r_rb;
            S_WR_A: begin
                rf_write    = 1'b1;
                rf_writenum = r_ra;
                rf_data_in  = (r_op == OP_LOADI) ? r_imm : r_tmp_b;
            end
            S_WR_B: begin
                rf_write    = 1'b1;
                rf_writenum = r_rb;
                rf_data_in  = r_tmp_a;
            end
            S_DONE:  done = ~reset;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_seq
// Description : Directed self-checking bench for regfile_seq with a register file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_seq;
    import regfile_seq_pkg::*;

    localparam int NCYC   = 8192;
    localparam int K_IDLE = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_DONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [2:0]  req_ra = 3'd0;
    logic [2:0]  req_rb = 3'd0;
    logic [15:0] req_imm = 16'h0;
    logic [15:0] rf_data_out;
    logic [2:0]  rf_readnum;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [15:0] rf_data_in;
    logic        done;
    logic [15:0] rsp_data;

    regfile_seq #(.DW(16), .AW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_ra      (req_ra),
        .req_rb      (req_rb),
        .req_imm     (req_imm),
        .rf_data_out (rf_data_out),
        .rf_readnum  (rf_readnum),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_data_in  (rf_data_in),
        .done        (done),
        .rsp_data    (rsp_data)
    );

    always #5 clk = ~clk;

    // Register file attached to the sequencer.
    logic [15:0] rf_mem [8];
    assign rf_data_out = rf_mem[rf_readnum];
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_acc = 0;
    bit started = 1'b0;

    // Expected per-cycle activity, indexed by absolute cycle number.
    int          s_kind [NCYC];
    logic [2:0]  s_rn   [NCYC];
    logic [2:0]  s_wn   [NCYC];
    logic [15:0] s_din  [NCYC];
    logic [15:0] s_rsp  [NCYC];
    bit          s_rd   [NCYC];
    logic [15:0] mregs  [8];
    logic [15:0] model_rsp;

    string       q_name [$];
    logic [31:0] q_act  [$];
    logic [31:0] q_exp  [$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
        q_name.push_back(name);
        q_act.push_back(act);
        q_exp.push_back(exp);
    endtask

    function automatic void sched(input int b, input logic [1:0] op, input logic [2:0] ra,
                                  input logic [2:0] rb, input logic [15:0] imm);
        int d;
        case (op)
            OP_LOADI: begin
                s_kind[b] = K_WR; s_wn[b] = ra; s_din[b] = imm;
                d = b + 1;
            end
            OP_MOV: begin
                s_kind[b]   = K_RD; s_rn[b] = rb;
                s_kind[b+1] = K_WR; s_wn[b+1] = ra; s_din[b+1] = mregs[rb];
                d = b + 2;
            end
            OP_SWAP: begin
                s_kind[b]   = K_RD; s_rn[b]   = ra;
                s_kind[b+1] = K_RD; s_rn[b+1] = rb;
                s_kind[b+2] = K_WR; s_wn[b+2] = ra; s_din[b+2] = mregs[rb];
                s_kind[b+3] = K_WR; s_wn[b+3] = rb; s_din[b+3] = mregs[ra];
                d = b + 4;
            end
            default: begin
                s_kind[b] = K_RD; s_rn[b] = ra;
                d = b + 1;
            end
        endcase
        s_kind[d] = K_DONE;
        s_rd[d]   = (op == OP_READ);
        s_rsp[d]  = mregs[ra];
    endfunction

    // Compare process: checks every cycle against the expected schedule.
    initial begin : compare
        int c;
        int k;
        for (int i = 0; i < NCYC; i++) begin
            s_kind[i] = K_IDLE; s_rn[i] = 3'd0; s_wn[i] = 3'd0;
            s_din[i] = 16'h0; s_rsp[i] = 16'h0; s_rd[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        model_rsp = 16'h0;
        forever begin
            @(negedge clk);
            while (q_name.size() > 0) chk(q_name.pop_front(), q_act.pop_front(), q_exp.pop_front());
            if (started) begin
                c = cyc;
                if (c + 8 >= NCYC) begin
                    n_err++;
                    $display("FAIL schedule_overflow at cycle %0d: got %0d expected below %0d", c, c, NCYC - 8);
                    started = 1'b0;
                end else begin
                    k = s_kind[c];
                    if (k == K_DONE && s_rd[c]) model_rsp = s_rsp[c];
                    chk("req_ready", {31'd0, req_ready}, {31'd0, (k == K_IDLE) && !reset});
                    chk("done", {31'd0, done}, {31'd0, (k == K_DONE) && !reset});
                    chk("rsp_data", {16'd0, rsp_data}, {16'd0, model_rsp});
                    chk("rf_write", {31'd0, rf_write}, {31'd0, k == K_WR});
                    if (k == K_WR) begin
                        chk("rf_writenum", {29'd0, rf_writenum}, {29'd0, s_wn[c]});
                        chk("rf_data_in", {16'd0, rf_data_in}, {16'd0, s_din[c]});
                        mregs[s_wn[c]] = s_din[c];
                    end else if (k == K_RD) begin
                        chk("rf_readnum", {29'd0, rf_readnum}, {29'd0, s_rn[c]});
                    end else begin
                        chk("quiet_readnum", {29'd0, rf_readnum}, 32'd0);
                        chk("quiet_writenum", {29'd0, rf_writenum}, 32'd0);
                        chk("quiet_data_in", {16'd0, rf_data_in}, 32'd0);
                    end
                    if (done === 1'b1) n_done++;
                    if (reset) begin
                        for (int j = c + 1; j < c + 8; j++) s_kind[j] = K_IDLE;
                        model_rsp = 16'h0;
                    end else if (req_valid && k == K_IDLE) begin
                        n_acc++;
                        sched(c + 1, req_op, req_ra, req_rb, req_imm);
                    end
                end
            end
        end
    end

    int          lat, nw, fw_cyc;
    logic [2:0]  fw_wn, rn1;
    logic [15:0] fw_din;

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [15:0] imm);
        bit got;
        bit seen;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_imm = imm;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) post("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        // Scramble fields after the accept edge; the command must be unaffected.
        req_valid = 1'b0; req_op = ~op; req_ra = ~ra; req_rb = ~rb; req_imm = ~imm;
        lat = 0; nw = 0; fw_cyc = 0; fw_wn = 3'd0; fw_din = 16'h0; rn1 = 3'd0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) rn1 = rf_readnum;
            if (rf_write) begin
                nw++;
                if (fw_cyc == 0) begin
                    fw_cyc = i; fw_wn = rf_writenum; fw_din = rf_data_in;
                end
            end
            if (done) begin
                seen = 1'b1;
                lat = i;
            end
        end
        if (!seen) post("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_expect(input string name, input logic [2:0] ra, input logic [15:0] exp);
        do_cmd(OP_READ, ra, 3'd0, 16'h0);
        post(name, {16'd0, rsp_data}, {16'd0, exp});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : driver
        int nd0, na0;
        repeat (3) @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        post("reset_ready", {31'd0, req_ready}, 32'd0);
        post("reset_rsp", {16'd0, rsp_data}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 8; i++) do_cmd(OP_LOADI, 3'(i), 3'd0, 16'h0A00 + 16'(i));

        // LOADI then READ
        do_cmd(OP_LOADI, 3'd3, 3'd0, 16'h00A5);
        post("loadi_latency", lat, 2);
        post("loadi_write_cycle", fw_cyc, 1);
        post("loadi_writenum", {29'd0, fw_wn}, 32'd3);
        post("loadi_data_in", {16'd0, fw_din}, 32'h00A5);
        post("loadi_nwrites", nw, 1);
        read_expect("read_r3", 3'd3, 16'h00A5);
        post("read_latency", lat, 2);

        // SWAP of distinct registers
        do_cmd(OP_LOADI, 3'd1, 3'd0, 16'h1234);
        do_cmd(OP_LOADI, 3'd2, 3'd0, 16'hBEEF);
        do_cmd(OP_SWAP, 3'd1, 3'd2, 16'h0);
        post("swap_latency", lat, 5);
        post("swap_first_write", fw_cyc, 3);
        post("swap_nwrites", nw, 2);
        post("swap_first_data", {16'd0, fw_din}, 32'hBEEF);
        read_expect("swap_r1", 3'd1, 16'hBEEF);
        read_expect("swap_r2", 3'd2, 16'h1234);

        // MOV R7 <= R0
        do_cmd(OP_LOADI, 3'd0, 3'd0, 16'h0042);
        do_cmd(OP_MOV, 3'd7, 3'd0, 16'h0);
        post("mov_readnum_c1", {29'd0, rn1}, 32'd0);
        post("mov_write_cycle", fw_cyc, 2);
        post("mov_writenum", {29'd0, fw_wn}, 32'd7);
        post("mov_data_in", {16'd0, fw_din}, 32'h0042);
        post("mov_latency", lat, 3);
        read_expect("mov_r0", 3'd0, 16'h0042);
        read_expect("mov_r7", 3'd7, 16'h0042);

        // SWAP with ra == rb
        do_cmd(OP_LOADI, 3'd4, 3'd0, 16'h5555);
        do_cmd(OP_SWAP, 3'd4, 3'd4, 16'h0);
        post("swap_same_nwrites", nw, 2);
        post("swap_same_data", {16'd0, fw_din}, 32'h5555);
        post("swap_same_latency", lat, 5);
        read_expect("swap_same_r4", 3'd4, 16'h5555);

        // req_valid held high with changing fields every cycle
        nd0 = n_done; na0 = n_acc;
        @(posedge clk); #1;
        req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req_op = 2'(i % 4); req_ra = 3'((i * 3) % 8); req_rb = 3'((i * 5 + 1) % 8);
            req_imm = 16'h1000 + 16'(i);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        post("stream_done_vs_accept", n_done - nd0, n_acc - na0);
        post("stream_some_accepts", {31'd0, (n_acc - na0) >= 5}, 32'd1);

        // Reset during the WR_A cycle of a SWAP
        do_cmd(OP_LOADI, 3'd1, 3'd0, 16'h1111);
        do_cmd(OP_LOADI, 3'd2, 3'd0, 16'h2222);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_SWAP; req_ra = 3'd1; req_rb = 3'd2; req_imm = 16'h0;
        begin : wait_acc
            bit got;
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                got = req_ready;
            end
            if (!got) post("reset_test_accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        nd0 = n_done;
        @(negedge clk);
        post("wr_a_at_reset", {28'd0, rf_write, rf_writenum}, {28'd0, 1'b1, 3'd1});
        @(posedge clk); #1;
        @(negedge clk);
        post("ready_in_reset", {31'd0, req_ready}, 32'd0);
        post("write_after_reset", {31'd0, rf_write}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        post("ready_after_reset", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        post("no_done_after_reset", n_done, nd0);
        read_expect("reset_r1", 3'd1, 16'h2222);
        read_expect("reset_r2", 3'd2, 16'h2222);

        @(negedge clk);
        for (int i = 0; i < 8; i++) post("final_reg", {16'd0, rf_mem[i]}, {16'd0, mregs[i]});
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
